// File: rtl/test_sequencer_pkg.sv
// Shared definitions for the test sequencer: FSM state encoding, the
// "latency not yet measured" sentinel, default driver pipeline depth and
// CAL timeout, and a saturating increment helper for the error counter.
package test_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CAL   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  localparam logic [31:0]  DELAY_UNMEASURED    = 32'h0000_FFFF;
  localparam int unsigned  DRV_LAT_DEFAULT     = 2;
  localparam int unsigned  CAL_TIMEOUT_DEFAULT = 1024;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/test_sequencer_counter.sv
// seq_counter: free-running up counter shared by the sequencer for the CAL
// wait count and the RUN/DRAIN cycle count.
//   clk_dut  in   clock
//   reset    in   asynchronous active-high reset
//   clr_i    in   synchronous clear (wins over en_i)
//   en_i     in   count enable
//   cnt_o    out  current count
module seq_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/test_sequencer.sv
// test_sequencer: runs one test campaign against a DUT. Waits for the DUT
// latency measurement, drives N operands, keeps the monitor compare window
// open for exactly N cycles aligned to the measured latency, and counts
// mismatches with an optional abort threshold.
//   clk_dut, reset        clock, asynchronous active-high reset
//   i_start               start pulse (accepted in IDLE/DONE only)
//   i_abort               abort a busy campaign
//   i_vec_count           vector count N
//   i_err_limit           mismatch abort threshold E (0 = off)
//   i_dut_delay           measured DUT latency, 32'h0000FFFF = unmeasured
//   i_mismatch            monitor compare-fail flag
//   o_lfsr_en, o_mon_en   registered generator / monitor enables
//   o_busy .. o_aborted   status flags
//   o_err_count           saturating mismatch count
//   o_checked             number of compare cycles
//   o_state               FSM state code
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE  0  | after reset, waiting for i_start
// CAL   1  | waiting for DUT latency measurement (bounded by CAL_TIMEOUT)
// RUN   2  | issuing N operands, monitor window may open
// DRAIN 3  | operands done, waiting for the last results to compare
// DONE  4  | campaign finished, results held until the next i_start
module test_sequencer
  import test_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CAL_TIMEOUT = CAL_TIMEOUT_DEFAULT,
  parameter int unsigned DRV_LAT     = DRV_LAT_DEFAULT
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_vec_count,
  input  logic [15:0]      i_err_limit,
  input  logic [WIDTH-1:0] i_dut_delay,
  input  logic             i_mismatch,
  output logic             o_lfsr_en,
  output logic             o_mon_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_timeout,
  output logic             o_aborted,
  output logic [15:0]      o_err_count,
  output logic [WIDTH-1:0] o_checked,
  output logic [2:0]       o_state
);

  localparam logic [WIDTH-1:0] CAL_LAST  = WIDTH'(CAL_TIMEOUT - 1);
  localparam logic [WIDTH:0]   DRV_LAT_W = (WIDTH+1)'(DRV_LAT);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [15:0]      e_q, e_d;
  logic [WIDTH:0]   l_q, l_d;
  logic [15:0]      err_q, err_d;
  logic [WIDTH-1:0] chk_q, chk_d;
  logic             timeout_q, timeout_d;
  logic             aborted_q, aborted_d;
  logic             lfsr_q, lfsr_d;
  logic             mon_q, mon_d;

  logic             cnt_clr, cnt_en;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH+1:0] drain_last;
  logic [WIDTH+1:0] r_nxt_x, win_lo, win_hi;
  logic             thresh_hit;

  seq_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk_dut (clk_dut),
    .reset   (reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .cnt_o   (cnt)
  );

  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      e_q       <= '0;
      l_q       <= '0;
      err_q     <= '0;
      chk_q     <= '0;
      timeout_q <= 1'b0;
      aborted_q <= 1'b0;
      lfsr_q    <= 1'b0;
      mon_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      e_q       <= e_d;
      l_q       <= l_d;
      err_q     <= err_d;
      chk_q     <= chk_d;
      timeout_q <= timeout_d;
      aborted_q <= aborted_d;
      lfsr_q    <= lfsr_d;
      mon_q     <= mon_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    e_d        = e_q;
    l_d        = l_q;
    err_d      = err_q;
    chk_d      = chk_q;
    timeout_d  = timeout_q;
    aborted_d  = aborted_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    r_nxt      = cnt;
    r_nxt_x    = '0;
    win_lo     = '0;
    win_hi     = '0;
    lfsr_d     = 1'b0;
    mon_d      = 1'b0;

    // Last DRAIN cycle is R == L+N-1; widened so large L never wraps.
    drain_last = {1'b0, l_q} + {2'b00, n_q} - (WIDTH+2)'(1);

    // Mismatches only count inside the compare window, which is mon_q.
    if (mon_q) begin
      chk_d = chk_q + WIDTH'(1);
      if (i_mismatch) begin
        err_d = sat_inc16(err_q);
      end
    end
    thresh_hit = mon_q && i_mismatch && (e_q != 16'd0) &&
                 (sat_inc16(err_q) == e_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          n_d       = i_vec_count;
          e_d       = i_err_limit;
          err_d     = '0;
          chk_d     = '0;
          timeout_d = 1'b0;
          aborted_d = 1'b0;
          cnt_clr   = 1'b1;
          state_d   = (i_vec_count == '0) ? ST_DONE : ST_CAL;
        end
      end
      ST_CAL: begin
        cnt_en = 1'b1;
        if (i_abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (i_dut_delay != DELAY_UNMEASURED) begin
          l_d     = {1'b0, i_dut_delay} + DRV_LAT_W;
          cnt_clr = 1'b1;
          state_d = ST_RUN;
        end else if (cnt == CAL_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (i_abort || thresh_hit) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (cnt == n_q - WIDTH'(1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_en = 1'b1;
        if (i_abort || thresh_hit) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if ({2'b00, cnt} >= drain_last) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Enables are registered, so they are decoded from next-cycle values
    // of the state and run counter.
    if (cnt_clr) begin
      r_nxt = '0;
    end else if (cnt_en) begin
      r_nxt = cnt + WIDTH'(1);
    end
    r_nxt_x = {2'b00, r_nxt};
    win_lo  = {1'b0, l_d};
    win_hi  = {1'b0, l_d} + {2'b00, n_d};
    lfsr_d  = (state_d == ST_RUN);
    mon_d   = ((state_d == ST_RUN) || (state_d == ST_DRAIN)) &&
              (r_nxt_x >= win_lo) && (r_nxt_x < win_hi);
  end

  assign o_lfsr_en   = lfsr_q;
  assign o_mon_en    = mon_q;
  assign o_busy      = (state_q == ST_CAL) || (state_q == ST_RUN) ||
                       (state_q == ST_DRAIN);
  assign o_done      = (state_q == ST_DONE);
  assign o_pass      = (state_q == ST_DONE) && (err_q == 16'd0) &&
                       !timeout_q && !aborted_q;
  assign o_timeout   = timeout_q;
  assign o_aborted   = aborted_q;
  assign o_err_count = err_q;
  assign o_checked   = chk_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench for test_sequencer. The reference model describes a
// campaign as a timeline: CAL length, RUN start, compare window
// [RUN start + L, RUN start + L + N) and end cycle, shortened by aborts and
// the error threshold as stimulus is applied.
module tb_test_sequencer;

  localparam int          T    = 16;
  localparam int          DLAT = 2;
  localparam logic [31:0] SENT = 32'h0000_FFFF;

  logic        clk_dut = 1'b0;
  logic        reset;
  logic        i_start, i_abort, i_mismatch;
  logic [31:0] i_vec_count, i_dut_delay;
  logic [15:0] i_err_limit;
  logic        o_lfsr_en, o_mon_en, o_busy, o_done, o_pass, o_timeout, o_aborted;
  logic [15:0] o_err_count;
  logic [31:0] o_checked;
  logic [2:0]  o_state;

  int n_checks = 0;
  int n_fail   = 0;

  test_sequencer #(.WIDTH(32), .CAL_TIMEOUT(T), .DRV_LAT(DLAT)) dut (
    .clk_dut     (clk_dut),
    .reset       (reset),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_vec_count (i_vec_count),
    .i_err_limit (i_err_limit),
    .i_dut_delay (i_dut_delay),
    .i_mismatch  (i_mismatch),
    .o_lfsr_en   (o_lfsr_en),
    .o_mon_en    (o_mon_en),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_pass      (o_pass),
    .o_timeout   (o_timeout),
    .o_aborted   (o_aborted),
    .o_err_count (o_err_count),
    .o_checked   (o_checked),
    .o_state     (o_state)
  );

  always #5 clk_dut = ~clk_dut;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {6'd0, o_state, o_busy, o_done, o_pass, o_timeout, o_aborted,
            o_lfsr_en, o_mon_en, o_err_count, o_checked};
  endfunction

  // n: vectors, e: error limit, dly: latency, kd: CAL cycle where the
  // latency becomes valid, ka: cycle of abort (-1 none), mis_pct: mismatch
  // probability, stop_at: leave the campaign early at that cycle (-1 none),
  // noise: pulse i_start randomly while busy.
  task automatic run_campaign(input int n, input int e, input int dly, input int kd,
                              input int ka, input int mis_pct, input int stop_at,
                              input bit noise);
    int rs, lat, endc, err, chkd, st;
    bit tmo, abt, fin, busy, ex_l, ex_m, ex_pass;
    logic [63:0] exp;
    i_vec_count = 32'(n);
    i_err_limit = 16'(e);
    i_dut_delay = SENT;
    i_abort     = 1'b0;
    i_mismatch  = 1'b0;
    i_start     = 1'b1;
    @(posedge clk_dut); #1;
    i_start = 1'b0;
    err = 0; chkd = 0; tmo = 0; abt = 0; fin = 0; exp = '0;
    lat = dly + DLAT;
    rs  = 0;
    if (n == 0) begin
      endc = 0;
    end else if (kd <= T - 1) begin
      rs   = kd + 1;
      endc = rs + lat + n;
    end else begin
      rs   = 1 << 30;
      endc = T;
      tmo  = 1;
    end
    for (int c = 0; c < 4000; c++) begin
      busy = (c < endc);
      if (!busy)            st = 4;
      else if (c < rs)      st = 1;
      else if (c < rs + n)  st = 2;
      else                  st = 3;
      ex_l    = busy && (c >= rs) && (c < rs + n);
      ex_m    = busy && (c >= rs) && (c - rs >= lat) && (c - rs < lat + n);
      ex_pass = !busy && (err == 0) && !tmo && !abt;
      exp = {6'd0, 3'(st), busy, !busy, ex_pass, !busy && tmo, !busy && abt,
             ex_l, ex_m, 16'(err), 32'(chkd)};
      chk_eq($sformatf("n%0d_d%0d_cyc%0d", n, dly, c), dut_vec(), exp);
      if (!busy || c == stop_at) begin
        fin = 1;
        break;
      end
      i_dut_delay = (c >= kd) ? 32'(dly) : SENT;
      i_abort     = (c == ka);
      i_mismatch  = ($urandom_range(99) < 32'(mis_pct));
      i_start     = noise && ($urandom_range(3) == 0);
      if (ex_m) begin
        chkd++;
        if (i_mismatch) begin
          if (err < 65535) err++;
          if (e != 0 && err == e) begin
            abt  = 1;
            endc = c + 1;
          end
        end
      end
      if (i_abort) begin
        abt  = 1;
        endc = c + 1;
      end
      @(posedge clk_dut); #1;
    end
    i_start = 1'b0; i_abort = 1'b0; i_mismatch = 1'b0;
    chk_eq("campaign_finished", 64'(fin), 64'd1);
    if (fin && stop_at < 0) begin
      for (int k = 0; k < 2; k++) begin
        i_abort    = 1'($urandom_range(1));
        i_mismatch = 1'($urandom_range(1));
        @(posedge clk_dut); #1;
        chk_eq("done_hold", dut_vec(), exp);
      end
      i_abort = 1'b0; i_mismatch = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    i_start = 1'b0; i_abort = 1'b0; i_mismatch = 1'b0;
    i_vec_count = '0; i_err_limit = '0; i_dut_delay = SENT;
    repeat (3) @(posedge clk_dut);
    #1 chk_eq("reset_state", dut_vec(), 64'd0);
    @(negedge clk_dut) reset = 1'b0;
    repeat (2) @(posedge clk_dut);
    #1 chk_eq("idle_after_reset", dut_vec(), 64'd0);

    run_campaign(8,   0, 3,  1,    -1, 0,   -1, 1'b0);  // basic, L=5
    run_campaign(4,   0, 10, 0,    -1, 0,   -1, 1'b0);  // window in DRAIN
    run_campaign(5,   0, 3,  1000, -1, 0,   -1, 1'b0);  // CAL timeout
    run_campaign(100, 3, 2,  0,    -1, 100, -1, 1'b0);  // error threshold
    run_campaign(10,  0, 2,  0,    4,  0,   -1, 1'b0);  // abort in RUN
    run_campaign(4,   0, 6,  0,    -1, 20,  10, 1'b0);  // stop mid-DRAIN
    #2 reset = 1'b1;
    #1 chk_eq("reset_mid_drain", dut_vec(), 64'd0);
    @(negedge clk_dut) reset = 1'b0;
    repeat (3) begin
      @(posedge clk_dut);
      #1 chk_eq("idle_hold", dut_vec(), 64'd0);
    end
    run_campaign(0,   0, 1,  0,    -1, 0,   -1, 1'b0);  // N=0
    run_campaign(6,   0, 1,  2,    -1, 30,  -1, 1'b1);  // start pulses ignored
    run_campaign(3,   0, 0,  T-1,  -1, 0,   -1, 1'b0);  // latency on last CAL cycle
    run_campaign(5,   2, 4,  0,    -1, 50,  -1, 1'b1);

    for (int i = 0; i < 16; i++) begin
      int n, e, dly, kd, ka, mis;
      n   = int'($urandom_range(0, 20));
      e   = int'($urandom_range(0, 4));
      dly = int'($urandom_range(0, 12));
      kd  = ($urandom_range(9) == 0) ? 100 : int'($urandom_range(0, 8));
      ka  = ($urandom_range(3) == 0) ? int'($urandom_range(0, 40)) : -1;
      mis = int'($urandom_range(0, 30));
      run_campaign(n, e, dly, kd, ka, mis, -1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, operand/data width; only 32 is supported.
REQ-002 Parameter CAL_TIMEOUT, default 1024, maximum cycles spent waiting for the DUT latency measurement.
REQ-003 Parameter DRV_LAT, default 2, driver operand-to-monitor pipeline depth in cycles.
REQ-004 clk_dut  input  1  clock for all state; reset, asynchronous, active-high.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 i_start  input  1  single-cycle start pulse; honoured only in IDLE or DONE.
REQ-007 i_abort  input  1  terminates any busy campaign.
REQ-008 i_vec_count  input  32  number of vectors N to issue.
REQ-009 i_err_limit  input  16  mismatch abort threshold E; 0 disables the threshold.
REQ-010 i_dut_delay  input  32  measured DUT latency; 32'h0000FFFF means not yet measured.
REQ-011 i_mismatch  input  1  monitor compare-fail flag, one per cycle.
REQ-012 o_lfsr_en  output  1  operand generator advance enable.
REQ-013 o_mon_en  output  1  monitor compare enable.
REQ-014 o_busy / o_done / o_pass / o_timeout / o_aborted  output  1 each  status flags.
REQ-015 o_err_count  output  16  saturating mismatch count.
REQ-016 o_checked  output  32  number of cycles with o_mon_en high.
REQ-017 o_state  output  3  current FSM state encoding.

Function
REQ-018 States SHALL be IDLE=0, CAL=1, RUN=2, DRAIN=3, DONE=4; codes 5-7 SHALL return to IDLE on the next cycle.
REQ-019 On i_start in IDLE or DONE: latch N and E; clear the counters, o_timeout and o_aborted; go to CAL, or go directly to DONE with o_pass=1 when N==0.
REQ-020 CAL: increment a wait counter each cycle.
- i_dut_delay != 32'h0000FFFF: latch L = i_dut_delay + DRV_LAT (33-bit); clear the run counter R; go to RUN.
- Wait counter reaches CAL_TIMEOUT-1 first: set o_timeout; go to DONE.
REQ-021 RUN: o_lfsr_en=1; R increments each cycle; go to DRAIN on the cycle where R==N-1.
REQ-022 DRAIN: o_lfsr_en=0; R keeps incrementing; go to DONE on the cycle where R==L+N-1 (34-bit compare, no wrap).
REQ-023 o_mon_en SHALL be high exactly when in RUN or DRAIN and L <= R < L+N, giving exactly N compare cycles; L >= N is legal, in which case the whole window falls in DRAIN.
REQ-024 i_mismatch SHALL be counted only when o_mon_en=1.
- o_err_count saturates at 16'hFFFF.
- o_checked increments on every o_mon_en cycle.
REQ-025 Error threshold: if E!=0 and the counted mismatch brings o_err_count to E, set o_aborted and go to DONE the next cycle.
REQ-026 i_abort in CAL, RUN or DRAIN: set o_aborted and go to DONE the next cycle; i_abort has priority over all other transitions and is ignored in IDLE and DONE.
REQ-027 i_start in CAL, RUN or DRAIN SHALL be ignored.
REQ-028 Status flags:
- o_busy=1 in CAL, RUN and DRAIN.
- o_done=1 in DONE only, as a level.
- o_pass=1 only in DONE with o_err_count==0, o_timeout=0 and o_aborted=0.
REQ-029 o_lfsr_en and o_mon_en SHALL be registered outputs.
REQ-030 Counters and flags SHALL hold their values in DONE until the next i_start.

Reset
REQ-031 Reset SHALL asynchronously force state IDLE and zero every output, counter and latched register.
REQ-032 Reset asserted mid-campaign SHALL drop o_lfsr_en and o_mon_en in the same cycle.
REQ-033 After reset deassertion the block SHALL remain in IDLE until i_start.

Structure
REQ-034 A shared package SHALL hold the state encoding constants, the 32'h0000FFFF not-measured sentinel and the DRV_LAT default.
REQ-035 The 32-bit run/wait counter SHALL be a sub-module, seq_counter, with clear, enable and count output; one instance serves CAL and RUN/DRAIN.

Verification
REQ-036 N=8, i_dut_delay=3 presented in the second CAL cycle, no mismatches -> o_lfsr_en high 8 cycles; o_mon_en high 8 cycles starting 5 cycles after RUN entry; DONE with o_pass=1, o_checked=8.
REQ-037 N=4, delay=10 -> o_mon_en window lies entirely in DRAIN, starting 12 cycles after RUN entry; o_checked=4.
REQ-038 i_dut_delay held at 32'h0000FFFF, CAL_TIMEOUT=16 -> DONE after 16 CAL cycles with o_timeout=1, o_pass=0, o_lfsr_en never high.
REQ-039 N=100, E=3, i_mismatch forced high -> DONE one cycle after the third counted mismatch; o_err_count=3, o_aborted=1.
REQ-040 i_abort in RUN, followed by reset mid-DRAIN in a second campaign -> first campaign ends in DONE with o_aborted=1; on reset all outputs are 0 the same cycle and state is IDLE.
REQ-041 N=0 start -> DONE the next cycle with o_pass=1 and o_lfsr_en never asserted; i_start pulses during RUN are ignored.
